// File: rtl/bram_rd_sched_pkg.sv
// Shared types and sizing helpers for the banked BRAM read scheduler.
package bram_rd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Words held per bank when an M x M matrix is split across N banks.
  function automatic int unsigned calc_depth(int unsigned m, int unsigned n);
    return (m * m) / n;
  endfunction

  // Step counter must reach DEPTH+N-2 in the skewed schedule.
  function automatic int unsigned calc_step_w(int unsigned depth, int unsigned n);
    return $clog2(depth + n);
  endfunction

  // Address/counter width with a floor of one bit for degenerate sizes.
  function automatic int unsigned calc_addr_w(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bank_fill_cnt.sv
// Per-bank fill counter: saturating word count, look-ahead full flag and
// overrun detect for one BRAM bank.
module bank_fill_cnt
  import bram_rd_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned CW    = calc_addr_w(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic idle,
  input  logic clr,
  output logic full_nxt_c,
  output logic ovr_c
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          at_max;

  assign at_max = (cnt == CW'(DEPTH));

  // Writes outside IDLE or into a full bank are flagged and not counted.
  assign ovr_c = wr_en && (!idle || at_max);

  // Next count: clear after a completed run, otherwise count accepted writes.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (wr_en && idle && !at_max) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Full is taken from the next count so the top can register it in step.
  assign full_nxt_c = (cnt_nxt == CW'(DEPTH));

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/bram_rd_sched.sv
// Read-side scheduler for N banked matrix BRAMs. Tracks bank fill from the
// write strobes, then streams every bank into the systolic array.
// Build option: BRAM_RD_SCHED_SKEW_EN selects the diagonal-skew schedule;
// without it all banks are read in lockstep.
module bram_rd_sched
  import bram_rd_sched_pkg::*;
#(
  parameter  int unsigned D_W   = 8,
  parameter  int unsigned N     = 3,
  parameter  int unsigned M     = 6,
  localparam int unsigned DEPTH = calc_depth(M, N),
  localparam int unsigned AW    = calc_addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  wr_en_bram,
  input  logic          start,
  output logic [AW-1:0] rd_addr_bram [N-1:0],
  output logic [N-1:0]  rd_en_bram,
  output logic [N-1:0]  out_valid,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic          overrun
);

  localparam int unsigned TW = calc_step_w(DEPTH, N);
  localparam int unsigned CW = calc_addr_w(DEPTH + 1);
`ifdef BRAM_RD_SCHED_SKEW_EN
  localparam int unsigned T_LAST = DEPTH + N - 2;
`else
  localparam int unsigned T_LAST = DEPTH - 1;
`endif

  // Data width only travels alongside this block; nothing here depends on it.
  logic [D_W-1:0] unused_dw;
  assign unused_dw = '0;

  state_e        state_q;
  state_e        state_nxt;
  logic [TW-1:0] t_q;
  logic [TW-1:0] t_nxt;
  logic [TW-1:0] rel;
  logic [N-1:0]  rd_en_c;
  logic [AW-1:0] rd_addr_c [N];
  logic          busy_c;
  logic          done_c;
  logic [N-1:0]  bank_full_nxt;
  logic [N-1:0]  bank_ovr;
  logic          in_idle;
  logic          in_done;

  assign in_idle = (state_q == IDLE);
  assign in_done = (state_q == DONE);

  // One fill counter per bank.
  for (genvar x = 0; x < N; x++) begin : g_bank
    bank_fill_cnt #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_fill (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en_bram[x]),
      .idle       (in_idle),
      .clr        (in_done),
      .full_nxt_c (bank_full_nxt[x]),
      .ovr_c      (bank_ovr[x])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start && full) state_nxt = RUN;
      RUN:     if (t_q == TW'(T_LAST)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and step-counter next values; addresses hold when a bank is idle.
  always_comb begin
    t_nxt   = '0;
    rel     = '0;
    rd_en_c = '0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    for (int x = 0; x < N; x++) begin
      rd_addr_c[x] = rd_addr_bram[x];
    end
    case (state_q)
      RUN: begin
        busy_c = 1'b1;
        t_nxt  = t_q + TW'(1);
        for (int x = 0; x < N; x++) begin
`ifdef BRAM_RD_SCHED_SKEW_EN
          rel = t_q - TW'(x);
          if ((t_q >= TW'(x)) && (rel < TW'(DEPTH))) begin
            rd_en_c[x]   = 1'b1;
            rd_addr_c[x] = AW'(rel);
          end
`else
          rel = t_q;
          if (rel < TW'(DEPTH)) begin
            rd_en_c[x]   = 1'b1;
            rd_addr_c[x] = AW'(rel);
          end
`endif
        end
      end
      DRAIN:   busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  // Output registers; out_valid trails the enables by the BRAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q        <= '0;
      rd_en_bram <= '0;
      out_valid  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
      overrun    <= 1'b0;
      for (int x = 0; x < N; x++) begin
        rd_addr_bram[x] <= '0;
      end
    end else begin
      t_q        <= t_nxt;
      rd_en_bram <= rd_en_c;
      out_valid  <= rd_en_bram;
      busy       <= busy_c;
      done       <= done_c;
      full       <= &bank_full_nxt;
      overrun    <= overrun | (|bank_ovr);
      for (int x = 0; x < N; x++) begin
        rd_addr_bram[x] <= rd_addr_c[x];
      end
    end
  end

endmodule

// File: tb/tb_bram_rd_sched.sv
// Self-checking bench for bram_rd_sched (N=3, M=6, DEPTH=12); follows the
// BRAM_RD_SCHED_SKEW_EN build option for its expected schedule.
`timescale 1ns/1ps
module tb_bram_rd_sched;

  localparam int unsigned D_W   = 8;
  localparam int unsigned N     = 3;
  localparam int unsigned M     = 6;
  localparam int unsigned DEPTH = (M * M) / N;
  localparam int unsigned AW    = $clog2(DEPTH);
`ifdef BRAM_RD_SCHED_SKEW_EN
  localparam bit          SKEW    = 1'b1;
  localparam int unsigned RUN_LEN = DEPTH + N - 1;
`else
  localparam bit          SKEW    = 1'b0;
  localparam int unsigned RUN_LEN = DEPTH;
`endif

  typedef struct packed {
    logic [N-1:0]         en;
    logic [N-1:0]         vld;
    logic [N-1:0][AW-1:0] addr;
    logic                 busy;
    logic                 done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  wr_en_bram;
  logic [AW-1:0] rd_addr_bram [N-1:0];
  logic [N-1:0]  rd_en_bram;
  logic [N-1:0]  out_valid;
  logic          busy;
  logic          done;
  logic          full;
  logic          overrun;

  exp_t                 sb[$];
  logic [N-1:0][AW-1:0] addr_model;
  int                   n_checks = 0;
  int                   n_fail   = 0;

  bram_rd_sched #(
    .D_W (D_W),
    .N   (N),
    .M   (M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en_bram   (wr_en_bram),
    .start        (start),
    .rd_addr_bram (rd_addr_bram),
    .rd_en_bram   (rd_en_bram),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done),
    .full         (full),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0][AW-1:0] get_addr();
    logic [N-1:0][AW-1:0] g;
    for (int x = 0; x < N; x++) g[x] = rd_addr_bram[x];
    return g;
  endfunction

  task automatic do_reset();
    rst        = 1'b0;
    start      = 1'b0;
    wr_en_bram = '0;
    addr_model = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Writes the given number of words to each bank with random gaps.
  task automatic fill(input int c0, input int c1, input int c2);
    int rem[N];
    rem[0] = c0; rem[1] = c1; rem[2] = c2;
    for (int it = 0; it < 400 && (rem[0] + rem[1] + rem[2]) > 0; it++) begin
      for (int x = 0; x < N; x++) begin
        wr_en_bram[x] = (rem[x] > 0) && ($urandom_range(0, 3) != 0);
        if (wr_en_bram[x]) rem[x]--;
      end
      @(posedge clk);
      #1;
    end
    wr_en_bram = '0;
  endtask

  // Expected outputs for cycles 1..RUN_LEN+3 after the accepting edge.
  task automatic push_run();
    exp_t         e;
    logic [N-1:0] prev_en;
    int           lo;
    prev_en = '0;
    for (int c = 1; c <= int'(RUN_LEN) + 3; c++) begin
      e.en = '0;
      for (int x = 0; x < N; x++) begin
        lo = SKEW ? x + 1 : 1;
        if (c >= lo && c <= lo + int'(DEPTH) - 1) begin
          e.en[x]       = 1'b1;
          addr_model[x] = AW'(c - lo);
        end
      end
      e.addr  = addr_model;
      e.vld   = prev_en;
      prev_en = e.en;
      e.busy  = (c <= int'(RUN_LEN) + 1);
      e.done  = (c == int'(RUN_LEN) + 2);
      sb.push_back(e);
    end
  endtask

  // Raises start so the next edge is cycle 0; optional stray write to bank 1.
  task automatic run_and_check(input int wr_cycle);
    exp_t                 e;
    logic [N-1:0][AW-1:0] got;
    int                   c;
    start = 1'b1;
    push_run();
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rd_en_bram !== '0) begin
      n_fail++;
      $display("FAIL cycle0_idle: busy=%b rd_en=%b, required busy=0 rd_en=000", busy, rd_en_bram);
    end
    c = 0;
    while (sb.size() > 0) begin
      if (c == wr_cycle) wr_en_bram = 3'b010;
      @(posedge clk);
      #1;
      wr_en_bram = '0;
      c++;
      e   = sb.pop_front();
      got = get_addr();
      n_checks++;
      if (rd_en_bram !== e.en) begin
        n_fail++;
        $display("FAIL rd_en c=%0d: got %b, required %b", c, rd_en_bram, e.en);
      end
      n_checks++;
      if (out_valid !== e.vld) begin
        n_fail++;
        $display("FAIL out_valid c=%0d: got %b, required %b", c, out_valid, e.vld);
      end
      n_checks++;
      if (got !== e.addr) begin
        n_fail++;
        $display("FAIL rd_addr c=%0d: got %h, required %h", c, got, e.addr);
      end
      n_checks++;
      if (busy !== e.busy || done !== e.done) begin
        n_fail++;
        $display("FAIL busy_done c=%0d: got %b%b, required %b%b", c, busy, done, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rd_en_bram, out_valid, busy, done, full, overrun} !== '0 || get_addr() !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outs=%b addr=%h, required all zero",
               {rd_en_bram, out_valid, busy, done, full, overrun}, get_addr());
    end
    fill(12, 12, 12);
    start = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rd_en_bram, out_valid, busy, done, full, overrun} !== '0 || get_addr() !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: outs=%b addr=%h, required all zero",
               {rd_en_bram, out_valid, busy, done, full, overrun}, get_addr());
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    addr_model = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (full !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL after_reset i=%0d: full=%b busy=%b done=%b, required 000", i, full, busy, done);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_fill_start();
    do_reset();
    fill(12, 12, 12);
    n_checks++;
    if (full !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b overrun=%b, required 1 0", full, overrun);
    end
    run_and_check(-1);
    n_checks++;
    if (full !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL post_run: full=%b overrun=%b, required 0 0", full, overrun);
    end
  endtask

  task automatic test_start_before_full();
    do_reset();
    fill(12, 12, 11);
    n_checks++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_full: full=%b, required 0", full);
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL start_ignored i=%0d: busy=%b, required 0", i, busy);
      end
    end
    // Final write with start still high: must wait for the registered full.
    wr_en_bram = 3'b100;
    @(posedge clk);
    #1;
    wr_en_bram = '0;
    run_and_check(-1);
  endtask

  task automatic test_overrun();
    do_reset();
    fill(12, 12, 12);
    wr_en_bram = 3'b001;
    @(posedge clk);
    #1;
    wr_en_bram = '0;
    n_checks++;
    if (overrun !== 1'b1 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_full_bank: overrun=%b full=%b, required 1 1", overrun, full);
    end
    run_and_check(-1);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
    end
    do_reset();
    fill(12, 12, 12);
    run_and_check(5);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_run: overrun=%b, required 1", overrun);
    end
    fill(11, 11, 11);
    n_checks++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL counters_cleared: full=%b, required 0", full);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(12, 12, 12);
    run_and_check(-1);
    fill(11, 11, 11);
    n_checks++;
    if (full !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_partial: full=%b, required 0", full);
    end
    fill(1, 1, 1);
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_full: full=%b, required 1", full);
    end
    run_and_check(-1);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: overrun=%b, required 0", overrun);
    end
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    wr_en_bram = '0;
    addr_model = '0;
    test_reset();
    test_fill_start();
    test_start_before_full();
    test_overrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_rd_sched.md
# bram_rd_sched

Read-side scheduler for the N banked matrix BRAMs that the write path fills. It tracks per-bank fill from the write strobes and accepts a start request once every bank holds M*M/N words. It then sequences the read addresses and enables so that each bank streams its contents into the systolic array with the diagonal skew the array needs, and signals completion. It sits between the BRAM read ports and the array's input edge and shares the BRAM write-enable bus as an observer only.

## Interface
- D_W, 8, data width (passed through; sets no logic here)
- N, 3, number of banks / array rows
- M, 6, matrix dimension; DEPTH = (M*M)/N words per bank, AW = $clog2(DEPTH)
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- wr_en_bram  input  N  per-bank write strobes, observed for fill tracking
- start  input  1  level request; hold until busy rises
- rd_addr_bram  output  AW x N  per-bank read address (unpacked [N-1:0])
- rd_en_bram  output  N  per-bank read enable
- out_valid  output  N  per-bank data-valid to array (rd_en_bram delayed 1 cycle, matches BRAM latency)
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse in DONE
- full  output  1  all banks hold DEPTH words
- overrun  output  1  sticky error: write strobe while busy or to a full bank

## Operation
- Fill counters: one per bank, 0..DEPTH, increment on wr_en_bram[x] while IDLE and below DEPTH, saturate at DEPTH. full = all counters == DEPTH (registered).
- overrun sets on wr_en_bram[x] when the bank is full or the state is not IDLE. It clears only on reset. The offending write is not counted.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start && full. The global step counter t is set to 0.
  - RUN: t increments every cycle. Bank x is enabled when x <= t < x+DEPTH, with rd_addr_bram[x] = t-x. RUN ends after t = DEPTH+N-2, then the state moves to DRAIN.
  - DRAIN: one cycle, for the last out_valid. Then the state moves to DONE.
  - DONE: one cycle with done=1. All fill counters clear to 0. Then the state moves to IDLE.
- start with full=0 is ignored; there is no queuing. full is registered, so start in the same cycle as the final write is not accepted until the next cycle.
- rd_addr_bram holds its last value when not enabled.
- Reset outputs: rd_addr_bram=0, rd_en_bram=0, out_valid=0, busy=0, done=0, full=0, overrun=0, state=IDLE, counters=0.
- Reset asserted mid-RUN aborts immediately to these values. No done pulse is produced.

## Timing
- Cycle 0: the edge on which start && full is sampled.
- RUN covers cycles 1..DEPTH+N-1. rd_en_bram[x] is high on cycles x+1..x+DEPTH, and the address counts 0..DEPTH-1 over that window.
- out_valid[x] is high on cycles x+2..x+DEPTH+1.
- DRAIN is cycle DEPTH+N; DONE/done is cycle DEPTH+N+1; IDLE follows from cycle DEPTH+N+2.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- BRAM_RD_SCHED_SKEW_EN defined: the diagonal skew described above applies. RUN length is DEPTH+N-1.
- BRAM_RD_SCHED_SKEW_EN undefined: all banks are enabled in lockstep on cycles 1..DEPTH, with rd_addr_bram[x] = t. RUN length is DEPTH.
- DRAIN and DONE follow RUN identically in both builds.

## Structure
- Package bram_rd_sched_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - a function computing DEPTH from M and N;
  - a function computing the step-counter width as $clog2(DEPTH+N).
- Sub-module bank_fill_cnt: one per bank via generate. It provides the saturating counter, per-bank full, and per-bank overrun detect. The top ANDs the full flags and ORs the overrun flags into the sticky register.

## Test plan
- Reset: with N=3, M=6 (DEPTH=12), drive rst=0 mid-stream. All outputs must be 0 and the state IDLE. After release, full=0.
- Fill and start: write 12 words to each bank, then assert start.
  - Cycle 1: rd_en_bram=3'b001, addr[0]=0.
  - Cycle 3: rd_en_bram=3'b111.
  - Cycle 14: rd_en_bram=3'b100, addr[2]=11.
  - done pulses on cycle 16.
- Start before full: assert start with bank 2 holding 11 words. The block must stay IDLE with busy=0. The 12th write followed by start one cycle later is accepted.
- Overrun: a 13th write to bank 0, and separately a write during RUN. overrun=1 and stays high. Counters must be unchanged.
- Lockstep build (BRAM_RD_SCHED_SKEW_EN undefined): rd_en_bram=3'b111 on cycles 1..12 with all addresses equal, and done on cycle 14.
- Back-to-back runs: after done, refill all banks and start again. The second run must match the first cycle-for-cycle, with counters restarting from 0.
